atm_account_arbiter: RTL and testbench

//   Shares one account-balance store between N_TERM atm_module-style terminals.

---
 rtl/atm_account_arbiter_if.sv | 34 +++
 rtl/atm_account_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_atm_account_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_account_arbiter_if.sv
// Terminal-side bundle of the shared account arbiter: the per-terminal
// request fields, the account lock vector and the response/status outputs.
interface atm_account_arbiter_if #(
  parameter int N_TERM = 4,
  parameter int TW     = 2,
  parameter int N_ACCT = 12,
  parameter int AW     = 4,
  parameter int BAL_W  = 16
);
  logic [N_TERM-1:0]       req;
  logic [2*N_TERM-1:0]     req_op;
  logic [AW*N_TERM-1:0]    req_acct;
  logic [BAL_W*N_TERM-1:0] req_amt;
  logic [N_ACCT-1:0]       acct_lock;

  logic [N_TERM-1:0]       ack;
  logic                    rsp_ok;
  logic [7:0]              rsp_err;
  logic [BAL_W-1:0]        rsp_bal;
  logic [TW-1:0]           grant_id;
  logic                    busy;

  // Terminal front-ends drive requests and observe responses.
  modport master (
    output req, req_op, req_acct, req_amt, acct_lock,
    input  ack, rsp_ok, rsp_err, rsp_bal, grant_id, busy
  );

  // The arbiter samples requests and drives responses.
  modport slave (
    input  req, req_op, req_acct, req_amt, acct_lock,
    output ack, rsp_ok, rsp_err, rsp_bal, grant_id, busy
  );
endinterface

// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter in front of a shared account-balance store. One granted
// request at a time runs as an atomic read-check-write sequence
// (IDLE -> READ -> EXEC -> RESP) and is answered with a one-cycle ack.
module atm_account_arbiter #(
  parameter int N_TERM = 4,
  parameter int TW     = 2,
  parameter int N_ACCT = 12,
  parameter int AW     = 4,
  parameter int BAL_W  = 16,
  parameter logic [BAL_W-1:0] INIT_BAL = 16'h1000
) (
  input logic clk,
  input logic rst_n,
  atm_account_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

  localparam logic [1:0] OP_WD  = 2'b01;
  localparam logic [1:0] OP_DEP = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  localparam logic [7:0] ERR_NONE  = 8'h00;
  localparam logic [7:0] ERR_FUNDS = 8'h01;
  localparam logic [7:0] ERR_ACCT  = 8'h02;
  localparam logic [7:0] ERR_OVF   = 8'h03;
  localparam logic [7:0] ERR_OP    = 8'h04;
  localparam logic [7:0] ERR_LOCK  = 8'h05;

  state_t              state_reg;
  logic [TW-1:0]       last_grant_reg;
  logic [TW-1:0]       grant_id_reg;
  logic [1:0]          op_reg;
  logic [AW-1:0]       acct_reg;
  logic [BAL_W-1:0]    amt_reg;
  logic [7:0]          err_reg;
  logic [BAL_W-1:0]    work_bal_reg;
  logic [N_TERM-1:0]   ack_reg;
  logic                rsp_ok_reg;
  logic [7:0]          rsp_err_reg;
  logic [BAL_W-1:0]    rsp_bal_reg;
  logic                busy_reg;

  logic [BAL_W-1:0]    bal_mem [N_ACCT];

  logic [1:0]          term_op   [N_TERM];
  logic [AW-1:0]       term_acct [N_TERM];
  logic [BAL_W-1:0]    term_amt  [N_TERM];
  logic [TW-1:0]       scan_id   [N_TERM];

  logic                pick_found;
  logic [TW-1:0]       pick_id;
  logic                acct_valid;
  logic                lock_hit;
  logic [BAL_W-1:0]    rd_bal;
  logic [BAL_W:0]      dep_sum;
  logic [7:0]          exec_err;
  logic [BAL_W-1:0]    exec_bal;
  logic                wr_req;
  logic                wr_en;

  // Split the flat request buses per terminal and build the round-robin scan
  // order: scan_id[0] is the terminal right after the last one granted.
  for (genvar gi = 0; gi < N_TERM; gi++) begin : g_term
    assign term_op[gi]   = bus.req_op[2*gi +: 2];
    assign term_acct[gi] = bus.req_acct[AW*gi +: AW];
    assign term_amt[gi]  = bus.req_amt[BAL_W*gi +: BAL_W];
    assign scan_id[gi]   = TW'((int'(last_grant_reg) + gi + 1) % N_TERM);
  end

  // First active requester in round-robin order.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = last_grant_reg;
    for (int i = 0; i < N_TERM; i++) begin
      if (!pick_found && bus.req[scan_id[i]]) begin
        pick_found = 1'b1;
        pick_id    = scan_id[i];
      end
    end
  end

  // An invalid account reads as zero, which is also the balance reported
  // with the invalid-account error.
  assign acct_valid = (acct_reg < AW'(N_ACCT));
  assign lock_hit   = acct_valid && bus.acct_lock[acct_reg];
  assign rd_bal     = acct_valid ? bal_mem[acct_reg] : '0;
  assign dep_sum    = {1'b0, work_bal_reg} + {1'b0, amt_reg};

  // Withdraw/deposit check on the latched balance; errors from READ pass through.
  always_comb begin
    exec_err = err_reg;
    exec_bal = work_bal_reg;
    wr_req   = 1'b0;
    if (err_reg == ERR_NONE) begin
      case (op_reg)
        OP_WD: begin
          if (amt_reg > work_bal_reg) begin
            exec_err = ERR_FUNDS;
          end else begin
            exec_bal = work_bal_reg - amt_reg;
            wr_req   = 1'b1;
          end
        end
        OP_DEP: begin
          if (dep_sum[BAL_W]) begin
            exec_err = ERR_OVF;
          end else begin
            exec_bal = dep_sum[BAL_W-1:0];
            wr_req   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_en = wr_req && (state_reg == EXEC);

  // Account store: reset to the initial balance, written at the EXEC->RESP edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < N_ACCT; a++) bal_mem[a] <= INIT_BAL;
    end else if (wr_en) begin
      bal_mem[acct_reg] <= exec_bal;
    end
  end

  // Transaction FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= TW'(N_TERM - 1);
      grant_id_reg   <= '0;
      op_reg         <= '0;
      acct_reg       <= '0;
      amt_reg        <= '0;
      err_reg        <= ERR_NONE;
      work_bal_reg   <= '0;
      ack_reg        <= '0;
      rsp_ok_reg     <= 1'b0;
      rsp_err_reg    <= ERR_NONE;
      rsp_bal_reg    <= '0;
      busy_reg       <= 1'b0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            op_reg         <= term_op[pick_id];
            acct_reg       <= term_acct[pick_id];
            amt_reg        <= term_amt[pick_id];
            grant_id_reg   <= pick_id;
            last_grant_reg <= pick_id;
            busy_reg       <= 1'b1;
            state_reg      <= READ;
          end
        end
        READ: begin
          work_bal_reg <= rd_bal;
          if (!acct_valid)           err_reg <= ERR_ACCT;
          else if (lock_hit)         err_reg <= ERR_LOCK;
          else if (op_reg == OP_BAD) err_reg <= ERR_OP;
          else                       err_reg <= ERR_NONE;
          state_reg <= EXEC;
        end
        EXEC: begin
          ack_reg     <= N_TERM'(1) << grant_id_reg;
          rsp_ok_reg  <= (exec_err == ERR_NONE);
          rsp_err_reg <= exec_err;
          rsp_bal_reg <= exec_bal;
          state_reg   <= RESP;
        end
        RESP: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ack      = ack_reg;
  assign bus.rsp_ok   = rsp_ok_reg;
  assign bus.rsp_err  = rsp_err_reg;
  assign bus.rsp_bal  = rsp_bal_reg;
  assign bus.grant_id = grant_id_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Bench for atm_account_arbiter: directed cases, randomized single-terminal
// traffic against a balance-array model, arbitration order, same-account
// serialisation and reset during a transaction.
module tb_atm_account_arbiter;
  localparam int N_TERM = 4;
  localparam int TW     = 2;
  localparam int N_ACCT = 12;
  localparam int AW     = 4;
  localparam int BAL_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int failures = 0;
  int model_bal [N_ACCT];
  int grant_log [$];
  int bal_log [$];
  int ok_log [$];

  always #5 clk = ~clk;

  atm_account_arbiter_if #(.N_TERM(N_TERM), .TW(TW), .N_ACCT(N_ACCT), .AW(AW), .BAL_W(BAL_W)) bus ();

  atm_account_arbiter #(.N_TERM(N_TERM), .TW(TW), .N_ACCT(N_ACCT), .AW(AW), .BAL_W(BAL_W),
                        .INIT_BAL(16'h1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: one atomic transaction on an integer balance array.
  function automatic void model_reset();
    for (int i = 0; i < N_ACCT; i++) model_bal[i] = 'h1000;
  endfunction

  function automatic void model_txn(input int op, input int acct, input int amt,
                                    input logic [N_ACCT-1:0] lock,
                                    output int err, output int bal);
    if (acct >= N_ACCT) begin
      err = 2; bal = 0;
    end else begin
      bal = model_bal[acct];
      if (lock[acct])   err = 5;
      else if (op == 3) err = 4;
      else if (op == 1) begin
        if (amt > bal) err = 1;
        else begin err = 0; bal = bal - amt; end
      end else if (op == 2) begin
        if (bal + amt > 65535) err = 3;
        else begin err = 0; bal = bal + amt; end
      end else err = 0;
      model_bal[acct] = bal;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Single-terminal transaction driver; the request fields are scrambled
  // right after the grant edge, so a correct result proves they were latched.
  task automatic issue(input int term, input int op, input int acct, input int amt,
                       output logic [N_TERM-1:0] ack_v, output logic ok,
                       output logic [7:0] err, output logic [BAL_W-1:0] bal,
                       output logic [TW-1:0] gid, output int lat,
                       output logic busy_seen, output logic [N_TERM-1:0] ack_after);
    ack_v = '0; ok = 1'b0; err = '0; bal = '0; gid = '0; lat = 0; busy_seen = 1'b0;
    bus.req_op[2*term +: 2]         = op[1:0];
    bus.req_acct[AW*term +: AW]     = acct[AW-1:0];
    bus.req_amt[BAL_W*term +: BAL_W] = amt[BAL_W-1:0];
    bus.req[term] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        busy_seen = bus.busy;
        bus.req_op[2*term +: 2]          = ~op[1:0];
        bus.req_acct[AW*term +: AW]      = ~acct[AW-1:0];
        bus.req_amt[BAL_W*term +: BAL_W] = ~amt[BAL_W-1:0];
      end
      if (bus.ack != '0) begin
        lat = c; ack_v = bus.ack; ok = bus.rsp_ok; err = bus.rsp_err;
        bal = bus.rsp_bal; gid = bus.grant_id;
        break;
      end
    end
    bus.req[term] = 1'b0;
    @(negedge clk);
    ack_after = bus.ack;
  endtask

  // Records acks as they arrive and drops each served terminal's request.
  task automatic collect_acks(input int n, input int budget);
    int idx;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        idx = -1;
        if ($onehot(bus.ack)) begin
          for (int k = 0; k < N_TERM; k++) if (bus.ack[k]) idx = k;
        end
        grant_log.push_back(idx);
        bal_log.push_back(int'(bus.rsp_bal));
        ok_log.push_back(int'(bus.rsp_ok));
        if (idx >= 0) bus.req[idx] = 1'b0;
        else bus.req = '0;
      end
      if (grant_log.size() >= n) break;
    end
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_op = '0; bus.req_acct = '0; bus.req_amt = '0; bus.acct_lock = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    checks++; if (bus.ack !== '0)    begin failures++; $display("FAIL reset ack: got %b want 0", bus.ack); end
    checks++; if (bus.rsp_ok !== 1'b0) begin failures++; $display("FAIL reset rsp_ok: got %b want 0", bus.rsp_ok); end
    checks++; if (bus.rsp_err !== 8'h00) begin failures++; $display("FAIL reset rsp_err: got %h want 00", bus.rsp_err); end
    checks++; if (bus.rsp_bal !== 16'h0000) begin failures++; $display("FAIL reset rsp_bal: got %h want 0000", bus.rsp_bal); end
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL reset grant_id: got %0d want 0", bus.grant_id); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    $display("reset: outputs checked");
  endtask

  task automatic test_directed();
    // term, op, acct, amt, lock account (-1 none), expected err, expected rsp_bal
    int tbl [8][7] = '{
      '{0, 0,  3, 'h0000, -1, 0, 'h1000},
      '{1, 1,  2, 'h0050, -1, 0, 'h0FB0},
      '{1, 1,  2, 'hFFFF, -1, 1, 'h0FB0},
      '{2, 2,  5, 'hF000, -1, 3, 'h1000},
      '{2, 2,  5, 'h0100, -1, 0, 'h1100},
      '{3, 0, 12, 'h0000, -1, 2, 'h0000},
      '{0, 1,  4, 'h0010,  4, 5, 'h1000},
      '{1, 3,  6, 'h0010, -1, 4, 'h1000}
    };
    logic [N_TERM-1:0] ack_v, ack_after;
    logic ok, busy_seen;
    logic [7:0] err;
    logic [BAL_W-1:0] bal;
    logic [TW-1:0] gid;
    logic [N_ACCT-1:0] lock;
    int lat, m_err, m_bal;
    for (int r = 0; r < 8; r++) begin
      lock = (tbl[r][4] >= 0) ? (N_ACCT'(1) << tbl[r][4]) : '0;
      bus.acct_lock = lock;
      model_txn(tbl[r][1], tbl[r][2], tbl[r][3], lock, m_err, m_bal);
      issue(tbl[r][0], tbl[r][1], tbl[r][2], tbl[r][3], ack_v, ok, err, bal, gid, lat, busy_seen, ack_after);
      bus.acct_lock = '0;
      $display("directed[%0d]: term=%0d op=%0d acct=%0d amt=%h -> err=%0d bal=%h lat=%0d",
               r, tbl[r][0], tbl[r][1], tbl[r][2], tbl[r][3], err, bal, lat);
      checks++; if (ack_v !== (N_TERM'(1) << tbl[r][0])) begin failures++; $display("FAIL directed[%0d] ack: got %b want term %0d", r, ack_v, tbl[r][0]); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL directed[%0d] latency: got %0d want 3", r, lat); end
      checks++; if (gid !== TW'(tbl[r][0])) begin failures++; $display("FAIL directed[%0d] grant_id: got %0d want %0d", r, gid, tbl[r][0]); end
      checks++; if (err !== 8'(tbl[r][5])) begin failures++; $display("FAIL directed[%0d] rsp_err: got %0d want %0d", r, err, tbl[r][5]); end
      checks++; if (bal !== 16'(tbl[r][6])) begin failures++; $display("FAIL directed[%0d] rsp_bal: got %h want %h", r, bal, tbl[r][6]); end
      checks++; if (ok !== (tbl[r][5] == 0)) begin failures++; $display("FAIL directed[%0d] rsp_ok: got %b want %b", r, ok, tbl[r][5] == 0); end
      checks++; if (ack_after !== '0) begin failures++; $display("FAIL directed[%0d] ack_pulse: got %b after ack cycle want 0", r, ack_after); end
      checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL directed[%0d] busy: got %b in READ want 1", r, busy_seen); end
    end
  endtask

  task automatic test_random();
    logic [N_TERM-1:0] ack_v, ack_after;
    logic ok, busy_seen;
    logic [7:0] err;
    logic [BAL_W-1:0] bal;
    logic [TW-1:0] gid;
    logic [N_ACCT-1:0] lock;
    int lat, term, op, acct, amt, m_err, m_bal;
    for (int n = 0; n < 40; n++) begin
      term = $urandom_range(0, N_TERM - 1);
      op   = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : 3;
      acct = $urandom_range(0, 13);
      amt  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 'h300);
      lock = ($urandom_range(0, 4) == 0) ? N_ACCT'($urandom) : '0;
      bus.acct_lock = lock;
      model_txn(op, acct, amt, lock, m_err, m_bal);
      issue(term, op, acct, amt, ack_v, ok, err, bal, gid, lat, busy_seen, ack_after);
      bus.acct_lock = '0;
      $display("random[%0d]: term=%0d op=%0d acct=%0d amt=%h lock=%h -> err=%0d bal=%h (model err=%0d bal=%h)",
               n, term, op, acct, amt, lock, err, bal, m_err, m_bal);
      checks++; if (ack_v !== (N_TERM'(1) << term)) begin failures++; $display("FAIL random[%0d] ack: got %b want term %0d", n, ack_v, term); end
      checks++; if (gid !== TW'(term)) begin failures++; $display("FAIL random[%0d] grant_id: got %0d want %0d", n, gid, term); end
      checks++; if (err !== 8'(m_err)) begin failures++; $display("FAIL random[%0d] rsp_err: got %0d want %0d", n, err, m_err); end
      checks++; if (bal !== 16'(m_bal)) begin failures++; $display("FAIL random[%0d] rsp_bal: got %h want %h", n, bal, m_bal); end
      checks++; if (ok !== (m_err == 0)) begin failures++; $display("FAIL random[%0d] rsp_ok: got %b want %b", n, ok, m_err == 0); end
    end
  endtask

  task automatic test_round_robin();
    int exp_a [4] = '{0, 1, 2, 3};
    int exp_b [2] = '{0, 2};
    int got;
    do_reset();
    grant_log.delete(); bal_log.delete(); ok_log.delete();
    for (int t = 0; t < N_TERM; t++) begin
      bus.req_op[2*t +: 2]          = 2'b00;
      bus.req_acct[AW*t +: AW]      = AW'(t);
      bus.req_amt[BAL_W*t +: BAL_W] = '0;
    end
    bus.req = 4'b1111;
    collect_acks(4, 60);
    checks++; if (grant_log.size() !== 4) begin failures++; $display("FAIL rr_all count: got %0d acks want 4", grant_log.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < grant_log.size()) ? grant_log[k] : -1;
      $display("rr_all: ack #%0d to terminal %0d", k, got);
      checks++; if (got !== exp_a[k]) begin failures++; $display("FAIL rr_all order[%0d]: got %0d want %0d", k, got, exp_a[k]); end
      got = (k < bal_log.size()) ? bal_log[k] : -1;
      checks++; if (got !== 'h1000) begin failures++; $display("FAIL rr_all rsp_bal[%0d]: got %h want 1000", k, got); end
    end
    grant_log.delete(); bal_log.delete(); ok_log.delete();
    bus.req = 4'b0101;
    collect_acks(2, 40);
    checks++; if (grant_log.size() !== 2) begin failures++; $display("FAIL rr_pair count: got %0d acks want 2", grant_log.size()); end
    for (int k = 0; k < 2; k++) begin
      got = (k < grant_log.size()) ? grant_log[k] : -1;
      $display("rr_pair: ack #%0d to terminal %0d", k, got);
      checks++; if (got !== exp_b[k]) begin failures++; $display("FAIL rr_pair order[%0d]: got %0d want %0d", k, got, exp_b[k]); end
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_same_account();
    logic [N_TERM-1:0] ack_v, ack_after;
    logic ok, busy_seen;
    logic [7:0] err;
    logic [BAL_W-1:0] bal;
    logic [TW-1:0] gid;
    int lat, m_err, m_bal, got;
    do_reset();
    grant_log.delete(); bal_log.delete(); ok_log.delete();
    bus.req_op[2*1 +: 2] = 2'b01; bus.req_acct[AW*1 +: AW] = 4'd7; bus.req_amt[BAL_W*1 +: BAL_W] = 16'h0100;
    bus.req_op[2*3 +: 2] = 2'b01; bus.req_acct[AW*3 +: AW] = 4'd7; bus.req_amt[BAL_W*3 +: BAL_W] = 16'h0100;
    bus.req = 4'b1010;
    collect_acks(2, 40);
    model_txn(1, 7, 'h100, '0, m_err, m_bal);
    model_txn(1, 7, 'h100, '0, m_err, m_bal);
    checks++; if (grant_log.size() !== 2) begin failures++; $display("FAIL same_acct count: got %0d acks want 2", grant_log.size()); end
    got = (bal_log.size() > 0) ? bal_log[0] : -1;
    $display("same_acct: first withdraw bal=%h", got);
    checks++; if (got !== 'h0F00) begin failures++; $display("FAIL same_acct first_bal: got %h want 0F00", got); end
    got = (bal_log.size() > 1) ? bal_log[1] : -1;
    $display("same_acct: second withdraw bal=%h", got);
    checks++; if (got !== 'h0E00) begin failures++; $display("FAIL same_acct second_bal: got %h want 0E00", got); end
    bus.req = '0;
    @(negedge clk);
    issue(0, 0, 7, 0, ack_v, ok, err, bal, gid, lat, busy_seen, ack_after);
    $display("same_acct: balance query acct 7 -> %h", bal);
    checks++; if (bal !== 16'h0E00) begin failures++; $display("FAIL same_acct final_bal: got %h want 0E00", bal); end
  endtask

  task automatic test_reset_mid();
    logic [N_TERM-1:0] ack_v, ack_after;
    logic ok, busy_seen;
    logic [7:0] err;
    logic [BAL_W-1:0] bal;
    logic [TW-1:0] gid;
    int lat, acks_seen;
    bus.req_op[2*2 +: 2] = 2'b01; bus.req_acct[AW*2 +: AW] = 4'd0; bus.req_amt[BAL_W*2 +: BAL_W] = 16'h0500;
    bus.req[2] = 1'b1;
    @(negedge clk);  // grant edge passed, in READ
    @(negedge clk);  // now in EXEC
    rst_n = 1'b0;
    acks_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack != '0) acks_seen++;
    end
    bus.req[2] = 1'b0;
    checks++; if (acks_seen !== 0) begin failures++; $display("FAIL reset_mid ack: got %0d ack cycles want 0", acks_seen); end
    checks++; if (bus.rsp_ok !== 1'b0) begin failures++; $display("FAIL reset_mid rsp_ok: got %b want 0", bus.rsp_ok); end
    checks++; if (bus.rsp_bal !== 16'h0000) begin failures++; $display("FAIL reset_mid rsp_bal: got %h want 0000", bus.rsp_bal); end
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL reset_mid grant_id: got %0d want 0", bus.grant_id); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_mid busy: got %b want 0", bus.busy); end
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    issue(0, 0, 0, 0, ack_v, ok, err, bal, gid, lat, busy_seen, ack_after);
    $display("reset_mid: acct 0 after aborted withdraw -> %h", bal);
    checks++; if (bal !== 16'h1000) begin failures++; $display("FAIL reset_mid acct0_bal: got %h want 1000", bal); end
    issue(1, 0, 7, 0, ack_v, ok, err, bal, gid, lat, busy_seen, ack_after);
    $display("reset_mid: acct 7 after reset -> %h", bal);
    checks++; if (bal !== 16'h1000) begin failures++; $display("FAIL reset_mid acct7_bal: got %h want 1000", bal); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_round_robin();
    test_same_account();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
